if_id_imm20_stage: RTL

//  IF/ID pipeline register with a 2-entry skid buffer between instruction fetch and decode.

---
 rtl/if_id_imm20_stage_pkg.sv | 16 +
 rtl/if_id_imm20_stage_imm20_extract.sv | 15 +
 rtl/if_id_imm20_stage.sv | 95 +++++++++
 3 files changed

// File: rtl/if_id_imm20_stage_pkg.sv
// if_id_imm20_stage_pkg: shared opcodes, immediate-kind encodings, NOP and the stage entry type.
package if_id_imm20_stage_pkg;
   localparam logic [6:0]  OP_LUI    = 7'b0110111;
   localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
   localparam logic [6:0]  OP_JAL    = 7'b1101111;
   localparam logic [1:0]  IMMK_NONE = 2'b00;
   localparam logic [1:0]  IMMK_U    = 2'b01;
   localparam logic [1:0]  IMMK_J    = 2'b10;
   localparam logic [31:0] NOP       = 32'h0000_0013;
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [19:0] imm20;
      logic [1:0]  kind;
   } entry_t;
endpackage

// File: rtl/if_id_imm20_stage_imm20_extract.sv
// if_id_imm20_stage_imm20_extract: combinational opcode decode producing the raw 20-bit immediate.
// Ports: instr_i (instruction), imm20_o (U field or J offset in halfwords), kind_o (IMMK_* encoding).
module if_id_imm20_stage_imm20_extract
   import if_id_imm20_stage_pkg::*;
(
   input  logic [31:0] instr_i,
   output logic [19:0] imm20_o,
   output logic [1:0]  kind_o
);
   assign kind_o  = (instr_i[6:0] == OP_LUI || instr_i[6:0] == OP_AUIPC) ? IMMK_U :
                    (instr_i[6:0] == OP_JAL) ? IMMK_J : IMMK_NONE;
   // J offset is reassembled into natural bit order, still in halfword units.
   assign imm20_o = (kind_o == IMMK_U) ? instr_i[31:12] :
                    (kind_o == IMMK_J) ? {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21]} : 20'h0;
endmodule

// File: rtl/if_id_imm20_stage.sv
// if_id_imm20_stage: IF/ID register with 2-entry skid buffer and pre-extracted 20-bit immediate.
// Ports: clk/rst (sync, active high); valid_in/ready_out/instr_in/pc_in from fetch; flush kills
// everything held; valid_out/ready_in/instr_out/pc_out/imm20_out/imm_kind towards decode.
// Optional IF_ID_PERF_CNT_EN adds stall_cnt and flush_cnt (wrapping 32-bit counters).
module if_id_imm20_stage
   import if_id_imm20_stage_pkg::*;
#(
   parameter int          XLEN   = 32,
   parameter logic [31:0] RST_PC = 32'h0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_in,
   output logic            ready_out,
   input  logic [XLEN-1:0] instr_in,
   input  logic [XLEN-1:0] pc_in,
   input  logic            flush,
   output logic            valid_out,
   input  logic            ready_in,
   output logic [XLEN-1:0] instr_out,
   output logic [XLEN-1:0] pc_out,
   output logic [19:0]     imm20_out,
   output logic [1:0]      imm_kind
`ifdef IF_ID_PERF_CNT_EN
   ,
   output logic [31:0]     stall_cnt,
   output logic [31:0]     flush_cnt
`endif
);
   if (XLEN != 32) begin : g_bad_xlen
      $error("if_id_imm20_stage: XLEN must be 32");
   end
   entry_t in_e, main_q, main_d, skid_q, skid_d;
   logic   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d, acc, drain;
   if_id_imm20_stage_imm20_extract u_ext (
      .instr_i (instr_in),
      .imm20_o (in_e.imm20),
      .kind_o  (in_e.kind)
   );
   assign in_e.instr = instr_in;
   assign in_e.pc    = pc_in;
   assign acc        = valid_in && ready_out;
   assign drain      = main_valid_q && ready_in;
   // Skid is only ever occupied while main is full, so main empty implies skid empty.
   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (drain || !main_valid_q) begin
         main_valid_d = skid_valid_q || acc;
         main_d       = skid_valid_q ? skid_q : acc ? in_e : main_q;
         skid_valid_d = 1'b0;
      end else if (acc) begin
         skid_valid_d = 1'b1;
         skid_d       = in_e;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         main_q       <= '{instr: NOP, pc: RST_PC, imm20: 20'h0, kind: IMMK_NONE};
         skid_q       <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         main_q       <= main_d;
         skid_q       <= skid_d;
      end
   end
   assign ready_out = !skid_valid_q;
   assign valid_out = main_valid_q;
   assign instr_out = main_q.instr;
   assign pc_out    = main_q.pc;
   assign imm20_out = main_q.imm20;
   assign imm_kind  = main_q.kind;
`ifdef IF_ID_PERF_CNT_EN
   logic [31:0] stall_cnt_q, flush_cnt_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= 32'h0;
         flush_cnt_q <= 32'h0;
      end else begin
         stall_cnt_q <= stall_cnt_q + {31'h0, main_valid_q && !ready_in};
         flush_cnt_q <= flush_cnt_q + {31'h0, flush};
      end
   end
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif
endmodule
